// File: rtl/led_pulse_stretcher_pkg.sv
// Shared types and timing defaults for the button/LED/display front-end blocks.
// The debouncer and the counter display share this tick base.
package led_pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } lps_state_t;

  localparam int unsigned DEF_DIV       = 100000;
  localparam int unsigned DEF_ON_TICKS  = 200;
  localparam int unsigned DEF_GAP_TICKS = 100;
  localparam int unsigned DEF_PEND_W    = 4;

  // Width of a counter that must reach max(on_t, gap_t).
  function automatic int unsigned tick_cnt_w(input int unsigned on_t, input int unsigned gap_t);
    int unsigned m;
    m = (on_t > gap_t) ? on_t : gap_t;
    return int'($clog2(m + 1));
  endfunction

endpackage

// File: rtl/led_pulse_stretcher_if.sv
// Event-in / LED-status-out bundle of the pulse stretcher.
interface led_pulse_stretcher_if
  import led_pulse_stretcher_pkg::*;
#(
  parameter int unsigned PEND_W = DEF_PEND_W
) ();

  logic              pulse;
  logic              led;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (output pulse, input led, input busy, input pending, input overflow);
  modport slave  (input pulse, output led, output busy, output pending, output overflow);

endinterface

// File: rtl/led_pulse_stretcher_tick_gen.sv
// Divide-by-DIV prescaler emitting a one-cycle tick; i_clr restarts the period.
module led_pulse_stretcher_tick_gen
  import led_pulse_stretcher_pkg::*;
#(
  parameter int unsigned DIV = DEF_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick_c
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick_c = (r_cnt == CW'(DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || o_tick_c) r_cnt <= '0;
    else                            r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/led_pulse_stretcher.sv
// Turns one-cycle events into distinct LED blinks; events arriving mid-blink
// are queued in a saturating counter and replayed back to back.
module led_pulse_stretcher
  import led_pulse_stretcher_pkg::*;
#(
  parameter int unsigned DIV       = DEF_DIV,
  parameter int unsigned ON_TICKS  = DEF_ON_TICKS,
  parameter int unsigned GAP_TICKS = DEF_GAP_TICKS,
  parameter int unsigned PEND_W    = DEF_PEND_W
) (
  input  logic                  CLK100MHZ,
  input  logic                  rst,
  led_pulse_stretcher_if.slave  bus
);

  localparam int unsigned     TW       = tick_cnt_w(ON_TICKS, GAP_TICKS);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  lps_state_t        r_state;
  logic [TW-1:0]     r_tcnt;
  logic [PEND_W-1:0] r_pending;
  logic              r_overflow;
  logic              r_led;
  logic              r_busy;

  logic w_tick;
  logic w_on_done;
  logic w_gap_done;
  logic w_consume;
  logic w_clr;

  assign w_on_done  = (r_state == ST_ON)  && w_tick && (r_tcnt == TW'(ON_TICKS - 1));
  assign w_gap_done = (r_state == ST_GAP) && w_tick && (r_tcnt == TW'(GAP_TICKS - 1));
  assign w_consume  = ((r_state == ST_IDLE) || w_gap_done) && (r_pending != '0);
  // Holding the prescaler clear in IDLE guarantees it starts at 0 on ON entry.
  assign w_clr      = (r_state == ST_IDLE) || w_on_done || w_gap_done;

  led_pulse_stretcher_tick_gen #(.DIV(DIV)) u_tick_gen (
    .i_clk    (CLK100MHZ),
    .i_rst    (rst),
    .i_clr    (w_clr),
    .o_tick_c (w_tick)
  );

  // Saturating queue of not-yet-started blinks; simultaneous +1/-1 cancel.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else if (bus.pulse && !w_consume) begin
      if (r_pending == PEND_MAX) r_overflow <= 1'b1;
      else                       r_pending  <= r_pending + PEND_W'(1);
    end else if (!bus.pulse && w_consume) begin
      r_pending <= r_pending - PEND_W'(1);
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tcnt  <= '0;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tcnt <= '0;
          if (w_consume) begin
            r_state <= ST_ON;
            r_led   <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_led   <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        ST_ON: begin
          if (w_on_done) begin
            r_state <= ST_GAP;
            r_tcnt  <= '0;
            r_led   <= 1'b0;
          end else if (w_tick) begin
            r_tcnt  <= r_tcnt + TW'(1);
          end
        end
        ST_GAP: begin
          if (w_gap_done) begin
            r_tcnt <= '0;
            if (w_consume) begin
              r_state <= ST_ON;
              r_led   <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (w_tick) begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tcnt  <= '0;
          r_led   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.led      = r_led;
  assign bus.busy     = r_busy;
  assign bus.pending  = r_pending;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher with DIV=4, ON_TICKS=3, GAP_TICKS=2, PEND_W=2.
module tb_led_pulse_stretcher;

  localparam int unsigned DIV   = 4;
  localparam int unsigned ON_T  = 3;
  localparam int unsigned GAP_T = 2;
  localparam int unsigned PW    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_pulse_stretcher_if #(.PEND_W(PW)) bus ();

  led_pulse_stretcher #(
    .DIV(DIV), .ON_TICKS(ON_T), .GAP_TICKS(GAP_T), .PEND_W(PW)
  ) dut (
    .CLK100MHZ (clk),
    .rst       (rst),
    .bus       (bus)
  );

  // Inputs held for ncyc cycles; expected outputs apply to each of those cycles.
  typedef struct {
    logic            rst;
    logic            pulse;
    int              ncyc;
    logic            led;
    logic            busy;
    logic [PW-1:0]   pend;
    logic            ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic p, input int n,
                     input logic l, input logic b, input int pd, input logic o);
    vec_t v;
    v.rst = r; v.pulse = p; v.ncyc = n;
    v.led = l; v.busy = b; v.pend = PW'(pd); v.ovf = o;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int idx,
                       input logic l, input logic b, input logic [PW-1:0] pd, input logic o);
    n_cmp++;
    if ({bus.led, bus.busy, bus.pending, bus.overflow} !== {l, b, pd, o}) begin
      n_bad++;
      $display("FAIL %s[%0d]: got led=%b busy=%b pend=%0d ovf=%b, want led=%b busy=%b pend=%0d ovf=%b",
               tag, idx, bus.led, bus.busy, bus.pending, bus.overflow, l, b, pd, o);
    end
  endtask

  int blinks;
  logic prev_led;

  initial begin
    // Single pulse at cycle 0.
    add(0,1, 1, 0,0,0,0);
    add(0,0, 1, 0,0,1,0);
    add(0,0,12, 1,1,0,0);
    add(0,0, 8, 0,1,0,0);
    add(0,0, 4, 0,0,0,0);
    // Pulses at 0,1,2: three blinks, busy unbroken.
    add(0,1, 1, 0,0,0,0);
    add(0,1, 1, 0,0,1,0);
    add(0,1, 1, 1,1,1,0);
    add(0,0,11, 1,1,2,0);
    add(0,0, 8, 0,1,2,0);
    add(0,0,12, 1,1,1,0);
    add(0,0, 8, 0,1,1,0);
    add(0,0,12, 1,1,0,0);
    add(0,0, 8, 0,1,0,0);
    add(0,0, 4, 0,0,0,0);
    // Pulse coincides with the GAP->ON consume: pending holds at 1.
    add(0,1, 1, 0,0,0,0);
    add(0,0, 1, 0,0,1,0);
    add(0,0, 3, 1,1,0,0);
    add(0,1, 1, 1,1,0,0);
    add(0,0, 8, 1,1,1,0);
    add(0,0, 7, 0,1,1,0);
    add(0,1, 1, 0,1,1,0);
    add(0,0,12, 1,1,1,0);
    add(0,0, 8, 0,1,1,0);
    add(0,0,12, 1,1,0,0);
    add(0,0, 8, 0,1,0,0);
    add(0,0, 4, 0,0,0,0);
    // Six pulses during ON: saturate at 3, sticky overflow, three more blinks.
    add(0,1, 1, 0,0,0,0);
    add(0,0, 1, 0,0,1,0);
    add(0,0, 2, 1,1,0,0);
    add(0,1, 1, 1,1,0,0);
    add(0,1, 1, 1,1,1,0);
    add(0,1, 1, 1,1,2,0);
    add(0,1, 1, 1,1,3,0);
    add(0,1, 2, 1,1,3,1);
    add(0,0, 4, 1,1,3,1);
    add(0,0, 8, 0,1,3,1);
    add(0,0,12, 1,1,2,1);
    add(0,0, 8, 0,1,2,1);
    add(0,0,12, 1,1,1,1);
    add(0,0, 8, 0,1,1,1);
    add(0,0,12, 1,1,0,1);
    add(0,0, 8, 0,1,0,1);
    add(0,0, 4, 0,0,0,1);
    // Only rst clears overflow.
    add(1,0, 1, 0,0,0,1);
    add(0,0, 2, 0,0,0,0);

    rst = 1'b1;
    bus.pulse = 1'b0;
    step();
    step();
    check("reset", 0, 1'b0, 1'b0, '0, 1'b0);
    // Reset beats a coincident pulse.
    bus.pulse = 1'b1;
    step();
    check("reset_pulse", 0, 1'b0, 1'b0, '0, 1'b0);
    rst = 1'b0;
    bus.pulse = 1'b0;
    step();
    check("reset_rel", 0, 1'b0, 1'b0, '0, 1'b0);

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].ncyc; c++) begin
        rst       = vecs[i].rst;
        bus.pulse = vecs[i].pulse;
        check("vec", i, vecs[i].led, vecs[i].busy, vecs[i].pend, vecs[i].ovf);
        step();
      end
    end
    rst = 1'b0;
    bus.pulse = 1'b0;

    // rst on cycle 7 of ON with pending=2 and pulse=1 discards everything.
    bus.pulse = 1'b1; step();
    bus.pulse = 1'b0; step(); step();
    bus.pulse = 1'b1; step(); step();
    bus.pulse = 1'b0;
    for (int c = 0; c < 4; c++) step();
    check("rst_pre", 0, 1'b1, 1'b1, PW'(2), 1'b0);
    rst = 1'b1;
    bus.pulse = 1'b1;
    step();
    rst = 1'b0;
    bus.pulse = 1'b0;
    check("rst_post", 0, 1'b0, 1'b0, '0, 1'b0);
    for (int c = 0; c < 40; c++) begin
      step();
      check("rst_quiet", c, 1'b0, 1'b0, '0, 1'b0);
    end

    // Pulse held high for three cycles counts as three events.
    blinks   = 0;
    prev_led = 1'b0;
    bus.pulse = 1'b1;
    for (int c = 0; c < 120; c++) begin
      if (c == 3) bus.pulse = 1'b0;
      if (bus.led && !prev_led) blinks++;
      prev_led = bus.led;
      step();
    end
    n_cmp++;
    if (blinks != 3) begin
      n_bad++;
      $display("FAIL held_blinks: got %0d blinks, want 3", blinks);
    end
    check("held_idle", 0, 1'b0, 1'b0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_pulse_stretcher.md
# led_pulse_stretcher

Output-side counterpart to the button debouncer: it takes the single-cycle press pulses the debouncer produces and turns each one into a distinct, human-visible LED blink. Events that arrive while a blink is in progress are queued in a saturating counter and replayed as separate blinks. The block sits between the debounced button pulse (or any one-cycle event source) and a board LED on the 100 MHz domain.

## Interface
Parameters:
- DIV, 100000: clock cycles per timing tick (1 ms at 100 MHz); DIV ≥ 2
- ON_TICKS, 200: ticks the LED stays lit per event; ≥ 1
- GAP_TICKS, 100: dark ticks enforced between consecutive blinks; ≥ 1
- PEND_W, 4: width of the pending-event counter (max 2^PEND_W−1 queued)

Ports:
- CLK100MHZ  in  1  the only clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- pulse  in  1  one-cycle event; each high cycle counts as one event
- led  out  1  registered LED drive, high during a blink
- busy  out  1  high whenever state ≠ IDLE
- pending  out  PEND_W  number of queued, not-yet-started blinks
- overflow  out  1  sticky; set when an event is dropped at saturation

## Operation
- Reset: state IDLE, led 0, busy 0, pending 0, overflow 0, prescaler 0, tick counter 0. Reset wins over pulse on the same cycle.
- Pending counter update per cycle: +1 if pulse, −1 if the FSM consumes an event. Both on the same cycle leave it unchanged. Saturates at 2^PEND_W−1. A pulse at saturation with no consume that cycle is dropped and sets overflow. overflow clears only on rst.
- FSM states: IDLE, ON, GAP.
  - IDLE: if pending > 0, consume one event and go to ON.
  - ON: after ON_TICKS ticks, go to GAP.
  - GAP: after GAP_TICKS ticks, if pending > 0 consume one event and go directly to ON; otherwise go to IDLE.
- Prescaler: counts 0..DIV−1; tick when it equals DIV−1. Both the prescaler and the tick counter zero on every state entry, so ON lasts exactly ON_TICKS·DIV cycles and GAP exactly GAP_TICKS·DIV cycles.
- led is a register set on entry to ON and cleared on exit from ON. busy is a register equal to (next state ≠ IDLE).

## Timing
- Latency: a pulse at cycle t raises pending at t+1. From IDLE, led and busy rise at t+2.
- Blink period: ON_TICKS·DIV cycles lit, then GAP_TICKS·DIV cycles dark. Back-to-back queued blinks start immediately after the gap, with no IDLE cycle between them.
- A pulse during ON or GAP never alters the current blink's timing; it is only queued.
- Arithmetic: prescaler width is $clog2(DIV); tick counter width is $clog2(max(ON_TICKS, GAP_TICKS)+1). All compares are unsigned.
- rst mid-operation: outputs take their reset values on the next edge, and any queue is discarded.

## Structure
- Shared package: FSM state enum (IDLE, ON, GAP) and the default timing constants, so the debouncer and the future counter display use the same tick base.
- One natural sub-module, tick_gen. It is a parameterised DIV prescaler with a synchronous clear input and a one-cycle tick output, and it can be reused by the debouncer in place of its free-running divided clock.
- The top level holds the pending counter, the FSM, and the output registers.

## Test plan
All scenarios use DIV=4, ON_TICKS=3, GAP_TICKS=2, PEND_W=2.
- Single pulse at cycle 0 -> pending=1 at cycle 1, 0 at cycle 2; led high cycles 2–13; busy high cycles 2–21; IDLE at 22.
- Pulses at cycles 0, 1, 2 -> led high 2–13, 22–33, 42–53; pending peaks at 2 on cycle 3; busy continuous 2–61.
- Six pulses on consecutive cycles starting while in ON -> pending saturates at 3, overflow=1 and stays 1; exactly three further blinks follow.
- Pulse on the same cycle the FSM consumes (GAP→ON with pending=1) -> pending stays 1; next blink follows after the gap.
- rst asserted at cycle 7 of ON with pending=2 and pulse=1 -> at the next edge led=0, busy=0, pending=0, overflow=0; no blink follows.
- pulse held high for 3 cycles from IDLE -> counted as 3 events, producing 3 blinks.
